// File: rtl/ahb_lite_master_if.sv
// ----------------------------------------------------------------------------
// ahb_lite_master_if
// Purpose : bundles the client request/response handshake and the AHB-Lite
//           master-side bus signals of ahb_lite_master.
// Modports:
//   master - view of the initiator (drives req_ready, rsp_*, HADDR, HWRITE,
//            HTRANS, HSIZE, HWDATA; samples req_*, HRDATA, HREADY, HRESP)
//   slave  - complementary view for whatever sits on the other side
//            (client + bus fabric)
// ----------------------------------------------------------------------------
interface ahb_lite_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // client side
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    // AHB-Lite bus side
    logic [AW-1:0] HADDR;
    logic          HWRITE;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic [DW-1:0] HWDATA;
    logic [DW-1:0] HRDATA;
    logic          HREADY;
    logic          HRESP;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HWRITE, HTRANS, HSIZE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HWRITE, HTRANS, HSIZE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_master.sv
// ----------------------------------------------------------------------------
// ahb_lite_master
// Purpose : AHB-Lite initiator. Turns single-word client requests into
//           pipelined NONSEQ transfers, honours HREADY wait states, handles
//           the two-cycle ERROR response (cancel + replay of the pipelined
//           transfer) and returns a one-cycle registered response pulse.
// Ports   :
//   HCLK    - bus clock, rising edge
//   HRESET  - asynchronous, active-high reset
//   bus     - ahb_lite_master_if.master (client req/rsp + AHB-Lite bus)
// ----------------------------------------------------------------------------
module ahb_lite_master #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic               HCLK,
    input logic               HRESET,
    ahb_lite_master_if.master bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    // address-phase register
    logic          ap_v;
    logic          ap_wr;
    logic [AW-1:2] ap_addr;
    logic [DW-1:0] ap_wdata;

    // data-phase register
    logic          dp_v;
    logic          dp_wr;
    logic [DW-1:0] dp_wdata;

    // set between the two ERROR cycles; suppresses the pending address phase
    logic          cx;

    logic          rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          rsp_err_q;

    logic          ready;
    logic          accept;

    // word transfers only: the byte-lane bits of the request are dropped
    logic          unused_addr_lsb;
    assign unused_addr_lsb = ^bus.req_addr[1:0];

    // A loaded AP can only be replaced on an advance edge, and nothing is
    // accepted while an error is being retired.
    assign ready  = ~cx & (~ap_v | bus.HREADY);
    assign accept = bus.req_valid & ready;

    assign bus.req_ready = ready;
    assign bus.HTRANS    = (ap_v & ~cx) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR     = {ap_addr, 2'b00};
    assign bus.HWRITE    = ap_wr;
    assign bus.HSIZE     = HSIZE_WORD;
    assign bus.HWDATA    = dp_wr ? dp_wdata : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ap_v        <= 1'b0;
            ap_wr       <= 1'b0;
            ap_addr     <= '0;
            ap_wdata    <= '0;
            dp_v        <= 1'b0;
            dp_wr       <= 1'b0;
            dp_wdata    <= '0;
            cx          <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // completion of whatever sits in the data phase
            rsp_valid_q <= dp_v & bus.HREADY;
            if (dp_v & bus.HREADY) begin
                rsp_rdata_q <= dp_wr ? '0 : bus.HRDATA;
                rsp_err_q   <= bus.HRESP;
            end

            if (cx) begin
                // second ERROR cycle: retire DP, keep AP for replay
                if (bus.HREADY) begin
                    dp_v  <= 1'b0;
                    dp_wr <= 1'b0;
                    cx    <= 1'b0;
                end
            end else if (bus.HREADY) begin
                // advance: AP moves into the data phase, AP reloads
                dp_v     <= ap_v;
                dp_wr    <= ap_v & ap_wr;
                dp_wdata <= ap_wdata;
                ap_v     <= accept;
                if (accept) begin
                    ap_wr    <= bus.req_write;
                    ap_addr  <= bus.req_addr[AW-1:2];
                    ap_wdata <= bus.req_wdata;
                end
            end else begin
                // wait state: only an empty AP may load (ready implies ~ap_v)
                if (accept) begin
                    ap_v     <= 1'b1;
                    ap_wr    <= bus.req_write;
                    ap_addr  <= bus.req_addr[AW-1:2];
                    ap_wdata <= bus.req_wdata;
                end
                // first ERROR cycle: drop HTRANS to IDLE next cycle
                if (dp_v & bus.HRESP) begin
                    cx <= 1'b1;
                end
            end
        end
    end
endmodule
